// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   MEM-stage load/store controller in front of a byte-addressed DataMemory.
//   It accepts one request at a time and checks its alignment. It then does
//   a single-cycle memory access, extends the load data, and holds the
//   response until the consumer takes it.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_load, req_size,        request attributes: 1=load/0=store,
//   req_signed, req_addr,      00 byte / 01 half / 10 word / 11 reserved,
//   req_wdata                  sign-extend loads, byte address, store data
//   resp_valid / resp_ready    response handshake
//   resp_data, resp_fault      extended load data (0 for stores/faults), fault
//   mem_A, mem_DI, mem_Size,   DataMemory address, write data, access size,
//   mem_RW, mem_E, mem_DO      write direction, write enable, read data
module mem_access_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_fault,
    output logic [7:0]  mem_A,
    output logic [31:0] mem_DI,
    output logic [1:0]  mem_Size,
    output logic        mem_RW,
    output logic        mem_E,
    input  logic [31:0] mem_DO
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t      state, state_next;

    logic        load_r;
    logic [1:0]  size_r;
    logic        signed_r;
    logic [7:0]  addr_r;
    logic [31:0] wdata_r;
    logic        fault_r;
    logic [31:0] data_r;

    logic        fault_in;
    logic [31:0] ext_data;
    logic        accept;

    // Alignment check on the incoming request; size 11 is always a fault.
    always_comb begin
        fault_in = 1'b0;
        case (req_size)
            2'b00:   fault_in = 1'b0;
            2'b01:   fault_in = req_addr[0];
            2'b10:   fault_in = |req_addr[1:0];
            default: fault_in = 1'b1;
        endcase
    end

    // Load data extension; words pass through regardless of signedness.
    always_comb begin
        ext_data = mem_DO;
        case (size_r)
            2'b00:   ext_data = {{24{signed_r & mem_DO[7]}}, mem_DO[7:0]};
            2'b01:   ext_data = {{16{signed_r & mem_DO[15]}}, mem_DO[15:0]};
            default: ext_data = mem_DO;
        endcase
    end

    assign accept = (state == IDLE) && req_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = fault_in ? RESP : ACCESS;
                end
            end
            ACCESS: state_next = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture; data_r is cleared on capture so stores and faults
    // respond with zero, and only a load in ACCESS overwrites it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_r   <= 1'b0;
            size_r   <= '0;
            signed_r <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            fault_r  <= 1'b0;
            data_r   <= '0;
        end else if (accept) begin
            load_r   <= req_load;
            size_r   <= req_size;
            signed_r <= req_signed;
            addr_r   <= req_addr;
            wdata_r  <= req_wdata;
            fault_r  <= fault_in;
            data_r   <= '0;
        end else if (state == ACCESS && load_r) begin
            data_r   <= ext_data;
        end
    end

    // Write strobes decode straight from the state register, so an
    // asynchronous reset removes them without waiting for a clock edge.
    assign mem_E      = (state == ACCESS) && !load_r;
    assign mem_RW     = (state == ACCESS) && !load_r;
    assign mem_A      = addr_r;
    assign mem_Size   = size_r;
    assign mem_DI     = wdata_r;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_data  = data_r;
    assign resp_fault = fault_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Scoreboard bench for mem_access_ctrl with a behavioural byte-wide
//   DataMemory model. The stimulus pushes the expected response when a request
//   is accepted. A separate monitor pops and compares at every response
//   handshake.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_fault;
    logic [7:0]  mem_A;
    logic [31:0] mem_DI;
    logic [1:0]  mem_Size;
    logic        mem_RW;
    logic        mem_E;
    logic [31:0] mem_DO;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_load   (req_load),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_fault (resp_fault),
        .mem_A      (mem_A),
        .mem_DI     (mem_DI),
        .mem_Size   (mem_Size),
        .mem_RW     (mem_RW),
        .mem_E      (mem_E),
        .mem_DO     (mem_DO)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } exp_t;
    exp_t q[$];

    // Little-endian byte memory with combinational read.
    logic [7:0] m [256];
    logic       init_done = 1'b0;

    always_comb begin
        mem_DO = '0;
        case (mem_Size)
            2'b00:   mem_DO = {24'h0, m[mem_A]};
            2'b01:   mem_DO = {16'h0, m[mem_A + 8'd1], m[mem_A]};
            2'b10:   mem_DO = {m[mem_A + 8'd3], m[mem_A + 8'd2], m[mem_A + 8'd1], m[mem_A]};
            default: mem_DO = '0;
        endcase
    end

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) m[i] <= 8'h00;
            m[0]  <= 8'h11; m[1]  <= 8'h22; m[2]  <= 8'h33; m[3]  <= 8'hF2;
            m[4]  <= 8'h55; m[5]  <= 8'h66; m[6]  <= 8'h01; m[7]  <= 8'h80;
            m[8]  <= 8'h01; m[9]  <= 8'h02; m[10] <= 8'h03; m[11] <= 8'h9A;
        end else if (mem_E && mem_RW) begin
            case (mem_Size)
                2'b00: m[mem_A] <= mem_DI[7:0];
                2'b01: begin
                    m[mem_A]        <= mem_DI[7:0];
                    m[mem_A + 8'd1] <= mem_DI[15:8];
                end
                2'b10: begin
                    m[mem_A]        <= mem_DI[7:0];
                    m[mem_A + 8'd1] <= mem_DI[15:8];
                    m[mem_A + 8'd2] <= mem_DI[23:16];
                    m[mem_A + 8'd3] <= mem_DI[31:24];
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: compare at every response handshake.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && resp_valid && resp_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got data=%h fault=%b expected no response",
                         resp_data, resp_fault);
            end else begin
                e = q.pop_front();
                chk("resp_data", resp_data, e.data);
                chk1("resp_fault", resp_fault, e.fault);
            end
        end
    end

    task automatic drive(input logic ld, input logic [1:0] sz, input logic sg,
                         input logic [7:0] a, input logic [31:0] wd);
        req_load   = ld;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic issue(input string nm, input logic ld, input logic [1:0] sz,
                         input logic sg, input logic [7:0] a, input logic [31:0] wd,
                         input logic [31:0] ed, input logic ef);
        int n;
        @(negedge clk);
        drive(ld, sz, sg, a, wd);
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL %s_accept: req_ready got 0 expected 1", nm);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        q.push_back('{ed, ef});
        #1 req_valid = 1'b0;
        @(negedge clk);
        // One cycle after acceptance: faults already respond, normal requests sit in ACCESS.
        chk1({nm, "_lat"}, resp_valid, ef);
        chk({nm, "_memA"}, {24'h0, mem_A}, {24'h0, a});
        chk({nm, "_memSize"}, {30'h0, mem_Size}, {30'h0, sz});
        chk({nm, "_memDI"}, mem_DI, wd);
        chk1({nm, "_memE"}, mem_E, !ld && !ef);
        chk1({nm, "_memRW"}, mem_RW, !ld && !ef);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_drain: pending got %0d expected 0", nm, q.size());
            q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        drive(1'b0, 2'b00, 1'b0, 8'h00, 32'h0);

        @(negedge clk);
        @(negedge clk);
        init_done = 1'b1;
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_resp_fault", resp_fault, 1'b0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_mem_A", {24'h0, mem_A}, 32'h0);
        chk("rst_mem_DI", mem_DI, 32'h0);
        chk("rst_mem_Size", {30'h0, mem_Size}, 32'h0);
        chk1("rst_mem_E", mem_E, 1'b0);
        chk1("rst_mem_RW", mem_RW, 1'b0);
        reset = 1'b0;

        // Reset lands in the middle of a byte-store ACCESS cycle.
        @(negedge clk);
        drive(1'b0, 2'b00, 1'b0, 8'h00, 32'h000000A6);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk1("r041_memE_pre", mem_E, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk1("r041_memE_rst", mem_E, 1'b0);
        chk1("r041_memRW_rst", mem_RW, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk1("r041_req_ready", req_ready, 1'b1);
        issue("r041_load0", 1'b1, 2'b10, 1'b0, 8'h00, 32'h0, 32'hF2332211, 1'b0);
        drain("r041");

        // Word store then read back.
        issue("st_w0c", 1'b0, 2'b10, 1'b0, 8'h0C, 32'h33445566, 32'h0, 1'b0);
        issue("ld_w0c", 1'b1, 2'b10, 1'b0, 8'h0C, 32'h0, 32'h33445566, 1'b0);
        // Byte and halfword extension.
        issue("ld_b03s", 1'b1, 2'b00, 1'b1, 8'h03, 32'h0, 32'hFFFFFFF2, 1'b0);
        issue("ld_b03u", 1'b1, 2'b00, 1'b0, 8'h03, 32'h0, 32'h000000F2, 1'b0);
        issue("ld_h06s", 1'b1, 2'b01, 1'b1, 8'h06, 32'h0, 32'hFFFF8001, 1'b0);
        issue("ld_h06u", 1'b1, 2'b01, 1'b0, 8'h06, 32'h0, 32'h00008001, 1'b0);
        // Signed word is not altered.
        issue("ld_w08s", 1'b1, 2'b10, 1'b1, 8'h08, 32'h0, 32'h9A030201, 1'b0);
        // Faults: misaligned word load, misaligned half store, reserved size.
        issue("f_ldw06", 1'b1, 2'b10, 1'b0, 8'h06, 32'h0, 32'h0, 1'b1);
        issue("f_sth05", 1'b0, 2'b01, 1'b0, 8'h05, 32'h0000BEEF, 32'h0, 1'b1);
        issue("f_rsv", 1'b1, 2'b11, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1);
        // Faulted store must not have touched memory.
        issue("ld_h04", 1'b1, 2'b01, 1'b0, 8'h04, 32'h0, 32'h00006655, 1'b0);
        // Byte store into the middle of the stored word.
        issue("st_b0d", 1'b0, 2'b00, 1'b0, 8'h0D, 32'h12345677, 32'h0, 1'b0);
        issue("ld_w0c2", 1'b1, 2'b10, 1'b0, 8'h0C, 32'h0, 32'h33447766, 1'b0);
        drain("main");

        // Back-pressure: response held while resp_ready=0, next request waits.
        @(negedge clk);
        resp_ready = 1'b0;
        drive(1'b1, 2'b00, 1'b0, 8'h03, 32'h0);
        req_valid = 1'b1;
        @(posedge clk);
        q.push_back('{32'h000000F2, 1'b0});
        #1 drive(1'b1, 2'b10, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        chk1("bp_access_valid", resp_valid, 1'b0);
        chk1("bp_access_ready", req_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("bp_hold_valid", resp_valid, 1'b1);
            chk("bp_hold_data", resp_data, 32'h000000F2);
            chk1("bp_hold_fault", resp_fault, 1'b0);
            chk1("bp_hold_req_ready", req_ready, 1'b0);
        end
        @(posedge clk);
        #2 resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // The handshake edge must not have taken the held request.
        chk1("bp_after_valid", resp_valid, 1'b0);
        chk1("bp_after_req_ready", req_ready, 1'b1);
        @(posedge clk);
        q.push_back('{32'hF2332211, 1'b0});
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk1("bp_second_accepted", req_ready, 1'b0);
        drain("bp");

        // Reset during RESP discards the response.
        @(negedge clk);
        resp_ready = 1'b0;
        drive(1'b1, 2'b10, 1'b0, 8'h08, 32'h0);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1("rr_valid_pre", resp_valid, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk1("rr_valid_rst", resp_valid, 1'b0);
        chk("rr_data_rst", resp_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        chk1("rr_valid_post", resp_valid, 1'b0);
        chk1("rr_req_ready_post", req_ready, 1'b1);

        repeat (3) @(negedge clk);
        chk("final_queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
